// File: rtl/demux14_pkg.sv
// Shared types and constants for the demux14 operand dispatcher.
// Lane count is fixed at four by the 2-bit lane select.
package demux14_pkg;
    localparam int LANES     = 4;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

    typedef logic [1:0] lane_sel_t;

    function automatic logic [LANES-1:0] sel_dec(input lane_sel_t s);
        return LANES'(1) << s;
    endfunction
endpackage

// File: rtl/demux14_if.sv
// Dispatcher bus: one upstream operand-pair channel, four lane outputs and counters.
// master = upstream producer/lane consumers, slave = the dispatcher.
interface demux14_if
    import demux14_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic                              in_valid;
    logic                              in_ready;
    lane_sel_t                         in_sel;
    logic [WIDTH-1:0]                  in_a;
    logic [WIDTH-1:0]                  in_b;
    logic [LANES-1:0]                  out_valid;
    logic [LANES-1:0]                  out_ready;
    logic [LANES-1:0][WIDTH-1:0]       out_a;
    logic [LANES-1:0][WIDTH-1:0]       out_b;
    logic [LANES-1:0][CNT_W-1:0]       issue_cnt;

    modport master (
        output in_valid, in_sel, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, issue_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, issue_cnt
    );
endinterface

// File: rtl/demux14_lane.sv
// One dispatcher lane: one-entry operand register with valid bit and
// a wrapping count of accepted transactions.
module dispatch_lane #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            count <= '0;
        end else if (load) begin
            // load wins over pop so a same-edge pop+load leaves no bubble
            valid <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            count <= count + CNT_W'(1);
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux14.sv
// One-to-four operand dispatcher: decodes in_sel, muxes in_ready from the
// selected lane, and packs the four lane registers onto the bus.
module demux14
    import demux14_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    demux14_if.slave  bus
);
    logic [LANES-1:0]            load;
    logic [LANES-1:0]            pop;
    logic [LANES-1:0]            vld;
    logic [LANES-1:0][WIDTH-1:0] a_q;
    logic [LANES-1:0][WIDTH-1:0] b_q;
    logic [LANES-1:0][CNT_W-1:0] cnt;
    logic                        rdy;

    // Ready depends only on the target lane, never on in_valid.
    assign rdy  = !vld[bus.in_sel] || bus.out_ready[bus.in_sel];
    assign load = sel_dec(bus.in_sel) & {LANES{bus.in_valid & rdy}};
    assign pop  = vld & bus.out_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dispatch_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[g]),
            .pop   (pop[g]),
            .a     (bus.in_a),
            .b     (bus.in_b),
            .valid (vld[g]),
            .a_q   (a_q[g]),
            .b_q   (b_q[g]),
            .count (cnt[g])
        );
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.issue_cnt = cnt;
endmodule

// File: tb/tb_demux14.sv
// Scoreboard bench for demux14: issued transactions are queued per lane,
// a negedge monitor checks out_valid and compares data on every pop.
module tb_demux14;
    import demux14_pkg::*;

    localparam int W  = 16;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    demux14_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    demux14 #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0]   q [LANES][$];
    logic [CW-1:0] exp_cnt [LANES];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: expected out_valid is "lane queue non-empty"; pops compare data.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                chk($sformatf("out_valid[%0d]", i), 32'(bus.out_valid[i]), 32'(q[i].size() != 0));
                if (bus.out_valid[i] && bus.out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("pop_empty[%0d]", i), 1, 0);
                    end else begin
                        logic [31:0] e;
                        e = q[i].pop_front();
                        chk($sformatf("pop_a[%0d]", i), 32'(bus.out_a[i]), 32'(e[31:16]));
                        chk($sformatf("pop_b[%0d]", i), 32'(bus.out_b[i]), 32'(e[15:0]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = '1;
        tick();
        bus.out_ready = '0;
    endtask

    task automatic check_cnts(input string nm);
        for (int i = 0; i < LANES; i++)
            chk($sformatf("%s_cnt[%0d]", nm, i), 32'(bus.issue_cnt[i]), 32'(exp_cnt[i]));
    endtask

    // Async reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < LANES; i++) begin
            q[i].delete();
            exp_cnt[i] = '0;
        end
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_a0", 32'(bus.out_a[0]), 0);
        check_cnts("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int s, input logic [W-1:0] a, input logic [W-1:0] b, input bit acc);
        bus.in_valid = 1'b1;
        bus.in_sel   = lane_sel_t'(s);
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        #1;
        chk($sformatf("in_ready_sel%0d", s), 32'(bus.in_ready), 32'(acc));
        if (acc) begin
            q[s].push_back({a, b});
            exp_cnt[s]++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = '0;
        #2;
        do_reset();

        // 1: reset with lanes 0 and 2 full, then first accept
        issue(0, 16'h0A0A, 16'h0B0B, 1'b1);
        issue(2, 16'h0C0C, 16'h0D0D, 1'b1);
        bus.in_valid = 1'b0;
        chk("t1_pre_valid", 32'(bus.out_valid), 'h5);
        do_reset();
        issue(1, 16'h1234, 16'h00FF, 1'b1);
        bus.in_valid = 1'b0;
        chk("t1_valid", 32'(bus.out_valid), 'h2);
        chk("t1_a1", 32'(bus.out_a[1]), 'h1234);
        chk("t1_b1", 32'(bus.out_b[1]), 'h00FF);
        chk("t1_cnt1", 32'(bus.issue_cnt[1]), 1);
        drain();

        // 2: backpressure on lane 3 blocks only lane 3
        issue(3, 16'hAAAA, 16'h0003, 1'b1);
        issue(3, 16'hBBBB, 16'h0004, 1'b0);
        chk("t2_hold_a3", 32'(bus.out_a[3]), 'hAAAA);
        issue(0, 16'h5555, 16'h0005, 1'b1);
        bus.in_valid = 1'b0;
        chk("t2_valid", 32'(bus.out_valid), 'h9);
        chk("t2_hold_a3b", 32'(bus.out_a[3]), 'hAAAA);
        check_cnts("t2");
        drain();

        // 3: same-edge pop and load on lane 2
        issue(2, 16'h0001, 16'h0101, 1'b1);
        bus.out_ready = 4'b0100;
        issue(2, 16'h0002, 16'h0202, 1'b1);
        bus.out_ready = '0;
        bus.in_valid  = 1'b0;
        chk("t3_valid2", 32'(bus.out_valid[2]), 1);
        chk("t3_a2", 32'(bus.out_a[2]), 'h0002);
        drain();

        // 4: 100 back-to-back transactions round-robin
        do_reset();
        bus.out_ready = '1;
        for (int i = 0; i < 100; i++)
            issue(i % 4, 16'(i), 16'(~i), 1'b1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < LANES; i++)
            chk($sformatf("t4_cnt25[%0d]", i), 32'(bus.issue_cnt[i]), 25);
        tick();
        bus.out_ready = '0;

        // 5: counter wrap on lane 0
        do_reset();
        bus.out_ready = '1;
        for (int i = 0; i < 256; i++)
            issue(0, 16'(i), 16'h00AA, 1'b1);
        bus.in_valid = 1'b0;
        chk("t5_wrap0", 32'(bus.issue_cnt[0]), 0);
        issue(0, 16'hFFFF, 16'h00BB, 1'b1);
        bus.in_valid = 1'b0;
        chk("t5_wrap1", 32'(bus.issue_cnt[0]), 1);
        tick();
        bus.out_ready = '0;

        // 6: independent drain of lanes 0 and 2
        for (int i = 0; i < LANES; i++)
            issue(i, 16'h0010 + 16'(i), 16'h0020 + 16'(i), 1'b1);
        bus.in_valid = 1'b0;
        chk("t6_full", 32'(bus.out_valid), 'hF);
        bus.out_ready = 4'b0101;
        tick();
        bus.out_ready = '0;
        chk("t6_valid", 32'(bus.out_valid), 'hA);
        chk("t6_a1", 32'(bus.out_a[1]), 'h0011);
        chk("t6_a3", 32'(bus.out_a[3]), 'h0013);
        check_cnts("t6");
        drain();
        tick();

        for (int i = 0; i < LANES; i++)
            chk($sformatf("end_q_empty[%0d]", i), 32'(q[i].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
